// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register file dump reader.
package regfile_pkg;

  localparam int RF_DW = 32;
  localparam int RF_AW = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SEND_LO = 3'd2,
    SEND_HI = 3'd3,
    DONE    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output beat stream of the dump reader.
// Handshake: a beat transfers on a rising clock edge where out_valid and out_ready
// are both high; once out_valid rises, out_data/out_index/out_last hold until that edge.
interface regfile_dump_reader_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register range two words at a time through the RF read ports and
// streams each value with its index; freezes RF writes while the dump runs.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [AW-1:0]         first_reg,
  input  logic [AW-1:0]         last_reg,
  output logic [AW-1:0]         Read1,
  output logic [AW-1:0]         Read2,
  input  logic [DW-1:0]         Data1,
  input  logic [DW-1:0]         Data2,
  regfile_dump_reader_if.master out_if,
  output logic                  freeze,
  output logic                  busy,
  output logic                  done,
  output dump_state_t           dbg_state
);

  dump_state_t   state_q, state_d;
  // One extra bit so that ptr+2 past the top register never wraps back to 0.
  logic [AW:0]   ptr_q, ptr_d;
  logic [AW-1:0] last_q, last_d;
  logic [DW-1:0] lo_q, lo_d;
  logic [DW-1:0] hi_q, hi_d;

  logic [AW:0]   ptr_p1;
  logic          lo_is_last;
  logic          hi_is_last;

  logic          valid_c;
  logic [DW-1:0] data_c;
  logic [AW-1:0] index_c;
  logic          last_c;

  assign ptr_p1     = ptr_q + (AW+1)'(1);
  assign lo_is_last = (ptr_q  == {1'b0, last_q});
  assign hi_is_last = (ptr_p1 == {1'b0, last_q});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    Read1   = '0;
    Read2   = '0;
    valid_c = 1'b0;
    data_c  = '0;
    index_c = '0;
    last_c  = 1'b0;
    freeze  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = {1'b0, first_reg};
          last_d  = last_reg;
          state_d = (first_reg <= last_reg) ? FETCH : DONE;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        freeze  = 1'b1;
        Read1   = ptr_q[AW-1:0];
        Read2   = ptr_p1[AW-1:0];
        lo_d    = Data1;
        hi_d    = Data2;
        state_d = SEND_LO;
      end
      SEND_LO: begin
        busy    = 1'b1;
        freeze  = 1'b1;
        valid_c = 1'b1;
        data_c  = lo_q;
        index_c = ptr_q[AW-1:0];
        last_c  = lo_is_last;
        if (out_if.out_ready) state_d = lo_is_last ? DONE : SEND_HI;
      end
      SEND_HI: begin
        busy    = 1'b1;
        freeze  = 1'b1;
        valid_c = 1'b1;
        data_c  = hi_q;
        index_c = ptr_p1[AW-1:0];
        last_c  = hi_is_last;
        if (out_if.out_ready) begin
          if (hi_is_last) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + (AW+1)'(2);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_if.out_valid = valid_c;
  assign out_if.out_data  = data_c;
  assign out_if.out_index = index_c;
  assign out_if.out_last  = last_c;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file, random back-pressure,
// expected-beat queue filled at start and drained by a negedge monitor.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  localparam int DW = RF_DW;
  localparam int AW = RF_AW;
  localparam int W  = AW + 1 + DW;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] Read1, Read2;
  logic [DW-1:0] Data1, Data2;
  logic          freeze, busy, done;
  dump_state_t   dbg_state;

  logic [DW-1:0] rf [32];
  logic [W-1:0]  exp_q [$];

  logic rdy_rand = 1'b0;
  logic rdy_fix  = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int freeze_cnt = 0;
  int valid_cnt = 0;
  int beat_cnt = 0;

  regfile_dump_reader_if #(.DW(DW), .AW(AW)) out_if ();

  regfile_dump_reader #(.DW(DW), .AW(AW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .Read1     (Read1),
    .Read2     (Read2),
    .Data1     (Data1),
    .Data2     (Data2),
    .out_if    (out_if.master),
    .freeze    (freeze),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  assign Data1 = rf[Read1];
  assign Data2 = rf[Read2];

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ready changes just after the edge, so each cycle sees one stable value.
  initial begin
    out_if.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      out_if.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    end
  end

  initial begin
    logic         stalled;
    logic [W-1:0] held, got, e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        stalled = 1'b0;
      end else begin
        got = {out_if.out_index, out_if.out_last, out_if.out_data};
        if (out_if.out_valid) valid_cnt++;
        if (freeze) freeze_cnt++;
        if (done) begin
          done_cnt++;
          check("freeze_in_done", 64'(freeze), 64'd0);
        end
        if (stalled && out_if.out_valid) check("stall_stable", 64'(got), 64'(held));
        if (out_if.out_valid && out_if.out_ready) begin
          beat_cnt++;
          check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat", 64'(got), 64'(e));
          end
        end
        stalled = out_if.out_valid && !out_if.out_ready;
        held    = got;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic start_dump(input int f, input int l, input bit push);
    tick();
    start     = 1'b1;
    first_reg = AW'(f);
    last_reg  = AW'(l);
    if (push) begin
      for (int i = f; i <= l; i++) exp_q.push_back({AW'(i), (i == l), rf[i]});
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    tick();
    tick();
  endtask

  initial begin
    int d0, f0, v0, b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hA5A5_0000 + 32'(i);

    #22;
    check("rst_valid", 64'(out_if.out_valid), 64'd0);
    check("rst_data", 64'(out_if.out_data), 64'd0);
    check("rst_index", 64'(out_if.out_index), 64'd0);
    check("rst_last", 64'(out_if.out_last), 64'd0);
    check("rst_ctrl", 64'({freeze, busy, done}), 64'd0);
    check("rst_reads", 64'({Read1, Read2}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    tick();
    reset_n = 1'b1;
    tick();

    // Two-beat dump with ready high: FETCH, SEND_LO, SEND_HI hold freeze.
    rf[17] = 32'd3;
    rf[18] = 32'd2;
    rdy_fix = 1'b1;
    tick();
    d0 = done_cnt; f0 = freeze_cnt; b0 = beat_cnt;
    start_dump(17, 18, 1'b1);
    check("fetch_read1", 64'(Read1), 64'd17);
    check("fetch_read2", 64'(Read2), 64'd18);
    check("fetch_no_valid", 64'(out_if.out_valid), 64'd0);
    check("fetch_busy", 64'(busy), 64'd1);
    tick();
    check("first_beat_latency", 64'(out_if.out_valid), 64'd1);
    wait_done(d0, 20);
    check("t1_freeze_cycles", 64'(freeze_cnt - f0), 64'd3);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_beats", 64'(beat_cnt - b0), 64'd2);

    // Full range with random back-pressure.
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 4);
    rdy_rand = 1'b1;
    d0 = done_cnt; b0 = beat_cnt;
    start_dump(0, 31, 1'b1);
    wait_done(d0, 600);
    check("t2_beats", 64'(beat_cnt - b0), 64'd32);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    rdy_rand = 1'b0;

    // Single top register: Read2 wraps to 0 and the hi word is dropped.
    rf[31] = 32'hDEAD_BEEF;
    rf[0]  = 32'h1234_5678;
    d0 = done_cnt; b0 = beat_cnt;
    start_dump(31, 31, 1'b1);
    check("t3_read1", 64'(Read1), 64'd31);
    check("t3_read2_wrap", 64'(Read2), 64'd0);
    wait_done(d0, 20);
    check("t3_beats", 64'(beat_cnt - b0), 64'd1);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // Empty range goes straight to DONE.
    d0 = done_cnt; f0 = freeze_cnt; v0 = valid_cnt;
    start_dump(5, 4, 1'b0);
    check("t4_done_now", 64'(done), 64'd1);
    tick();
    tick();
    check("t4_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("t4_no_freeze", 64'(freeze_cnt - f0), 64'd0);
    check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);

    // A second start while busy is ignored.
    rdy_rand = 1'b1;
    d0 = done_cnt; b0 = beat_cnt;
    start_dump(0, 7, 1'b1);
    tick();
    tick();
    start_dump(20, 25, 1'b0);
    wait_done(d0, 200);
    tick();
    tick();
    check("t5_beats", 64'(beat_cnt - b0), 64'd8);
    check("t5_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
    rdy_rand = 1'b0;

    // Reset in SEND_HI aborts silently; a fresh dump then runs normally.
    rdy_fix = 1'b1;
    d0 = done_cnt;
    start_dump(0, 7, 1'b1);
    for (int i = 0; i < 20 && dbg_state != SEND_HI; i++) tick();
    check("t6_reached_send_hi", 64'(dbg_state), 64'(SEND_HI));
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_if.out_valid), 64'd0);
    check("t6_rst_stream", 64'({out_if.out_index, out_if.out_last, out_if.out_data}), 64'd0);
    check("t6_rst_ctrl", 64'({freeze, busy, done}), 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    b0 = beat_cnt;
    start_dump(3, 6, 1'b1);
    wait_done(d0, 40);
    check("t6_beats", 64'(beat_cnt - b0), 64'd4);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
